// File: rtl/ppa_pkg.sv
// ----------------------------------------------------------------------------
// ppa_pkg
//   Shared types and elaboration-time helpers for the pipelined Kogge-Stone
//   adder (ppa_adder_pipe) and its black cell (ppa_gp_cell).
//
//   gp_t          one (generate, propagate) pair
//   clog2         ceil(log2(n)), number of prefix levels for a given width
//   cut_level     prefix level after which register cut k sits
//   cut_at_level  inverse lookup: which cut (if any) sits after a given level
//   gp_combine    black-cell operator (G,P)o(G',P') = (G|P&G', P&P')
// ----------------------------------------------------------------------------
package ppa_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Cut k (1..stages-1) follows prefix level floor(k*levels/(stages-1)).
    // The last cut always lands after the final level.
    function automatic int cut_level(input int k, input int levels, input int stages);
        if (stages < 2) return levels;
        return (k * levels) / (stages - 1);
    endfunction

    // Returns the cut index that sits right after 'lvl' completed levels,
    // or 0 when that boundary is purely combinational. Cut levels are strictly
    // increasing because stages-1 <= levels, so the answer is unique.
    function automatic int cut_at_level(input int lvl, input int levels, input int stages);
        int hit;
        hit = 0;
        for (int k = 1; k < stages; k++)
            if (cut_level(k, levels, stages) == lvl) hit = k;
        return hit;
    endfunction

    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t o;
        o.g = hi.g | (hi.p & lo.g);
        o.p = hi.p & lo.p;
        return o;
    endfunction

endpackage

// File: rtl/ppa_gp_cell.sv
// ----------------------------------------------------------------------------
// ppa_gp_cell
//   One combinational Kogge-Stone black cell.
//   hi  (G,P) of the more significant span
//   lo  (G,P) of the adjacent less significant span
//   o   merged (G,P) covering both spans
// ----------------------------------------------------------------------------
module ppa_gp_cell
    import ppa_pkg::*;
(
    input  gp_t hi,
    input  gp_t lo,
    output gp_t o
);

    assign o = gp_combine(hi, lo);

endmodule

// File: rtl/ppa_adder_pipe.sv
// ----------------------------------------------------------------------------
// ppa_adder_pipe
//   Pipelined parallel-prefix (Kogge-Stone) adder with valid/ready handshake.
//   {ov,w} = a + b + c  (or a + ~b + c when 'sub' is set in the PPA_SUB_EN build).
//
//   Parameters
//     WIDTH   operand / sum width (>= 2)
//     STAGES  register stages from accept to result, 1..clog2(WIDTH)+1
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     in_valid/in_ready   operand beat handshake
//     a, b, c             operands and carry-in
//     sub                 (PPA_SUB_EN only) invert b for this beat
//     out_valid/out_ready result beat handshake
//     w, ov, sovf         sum, carry-out, signed overflow
//
//   Build option: define PPA_SUB_EN to add the 'sub' input.
//
//   Stage 0 captures the generate/propagate vectors of the accepted operands.
//   Cut k (k>=1) captures the prefix tree after level cut_level(k). The final
//   carry chain and sum XOR are combinational after the last stage register.
// ----------------------------------------------------------------------------
module ppa_adder_pipe
    import ppa_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
`ifdef PPA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] w,
    output logic             ov,
    output logic             sovf
);

    localparam int L  = clog2(WIDTH);
    // Cut feeding the final sum; 0 means the tree output is used directly.
    localparam int KF = cut_at_level(L, L, STAGES);

    typedef struct packed {
        gp_t [WIDTH-1:0]  gp;  // prefix state at this cut
        logic [WIDTH-1:0] pp;  // bitwise propagate, needed for the sum XOR
        logic             c;   // carry-in, needed for sum bit 0
    } stage_t;

    logic [STAGES-1:0] vld_q;
    logic [STAGES:0]   load;
    logic [STAGES-1:0] stg_en;
    stage_t            stg_q  [STAGES];
    stage_t            stg_d  [STAGES];
    gp_t [WIDTH-1:0]   cut_gp [STAGES];
    gp_t [WIDTH-1:0]   gen_gp;
    gp_t [WIDTH-1:0]   lv0;
    gp_t [WIDTH-1:0]   fin;
    logic [WIDTH-1:0]  b_eff;
    logic [WIDTH:0]    cy;
    logic [WIDTH-1:0]  unused_fin_p;

    // ------------------------------------------------------------------
    // Operand conditioning and bitwise generate/propagate
    // ------------------------------------------------------------------
`ifdef PPA_SUB_EN
    assign b_eff = sub ? ~b : b;
`else
    assign b_eff = b;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_gen
        assign gen_gp[i].g = a[i] & b_eff[i];
        assign gen_gp[i].p = a[i] ^ b_eff[i];
    end

    assign cut_gp[0] = gen_gp;

    // ------------------------------------------------------------------
    // Flow control. A stage loads when it, or any stage downstream of it,
    // is empty, or when the consumer is taking the head beat. Writing it as
    // a reduction instead of a chain keeps bubbles collapsing in one cycle.
    // ------------------------------------------------------------------
    assign load[STAGES] = out_ready;
    for (genvar i = 0; i < STAGES; i++) begin : g_load
        assign load[i] = out_ready | ~(&vld_q[STAGES-1:i]);
    end

    assign in_ready  = load[0];
    assign out_valid = vld_q[STAGES-1];

    always_comb begin
        stg_en    = '0;
        stg_en[0] = in_valid & load[0];
        for (int k = 1; k < STAGES; k++)
            stg_en[k] = vld_q[k-1] & load[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            if (load[0]) vld_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++)
                if (load[k]) vld_q[k] <= vld_q[k-1];
        end
    end

    // ------------------------------------------------------------------
    // Stage payload registers. Payload only moves with a valid beat so
    // an idle input bus never disturbs a held result.
    // ------------------------------------------------------------------
    always_comb begin
        stg_d[0].gp = cut_gp[0];
        stg_d[0].pp = a ^ b_eff;
        stg_d[0].c  = c;
        for (int k = 1; k < STAGES; k++) begin
            stg_d[k].gp = cut_gp[k];
            stg_d[k].pp = stg_q[k-1].pp;
            stg_d[k].c  = stg_q[k-1].c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) stg_q[k] <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++)
                if (stg_en[k]) stg_q[k] <= stg_d[k];
        end
    end

    // ------------------------------------------------------------------
    // Prefix tree. The carry-in is folded into bit 0 as g[-1]=c, so after
    // the last level G[i] is directly the carry into bit i+1.
    // ------------------------------------------------------------------
    always_comb begin
        lv0    = stg_q[0].gp;
        lv0[0] = gp_combine(stg_q[0].gp[0], gp_t'{g: stg_q[0].c, p: 1'b0});
    end

    for (genvar j = 0; j < L; j++) begin : g_lvl
        localparam int K    = cut_at_level(j, L, STAGES);
        localparam int SPAN = 1 << j;
        gp_t [WIDTH-1:0] src;
        gp_t [WIDTH-1:0] nxt;

        if (K > 0) begin : g_from_reg
            assign src = stg_q[K].gp;
        end else if (j == 0) begin : g_from_fold
            assign src = lv0;
        end else begin : g_from_prev
            assign src = g_lvl[j-1].nxt;
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= SPAN) begin : g_cell
                ppa_gp_cell u_cell (
                    .hi (src[i]),
                    .lo (src[i-SPAN]),
                    .o  (nxt[i])
                );
            end else begin : g_pass
                assign nxt[i] = src[i];
            end
        end
    end

    for (genvar k = 1; k < STAGES; k++) begin : g_cut
        localparam int CL = cut_level(k, L, STAGES);
        assign cut_gp[k] = g_lvl[CL-1].nxt;
    end

    if (KF > 0) begin : g_fin_reg
        assign fin = stg_q[KF].gp;
    end else begin : g_fin_comb
        assign fin = g_lvl[L-1].nxt;
    end

    // ------------------------------------------------------------------
    // Sum, carry-out and signed overflow
    // ------------------------------------------------------------------
    always_comb begin
        cy[0] = stg_q[STAGES-1].c;
        for (int i = 0; i < WIDTH; i++) begin
            cy[i+1]         = fin[i].g;
            unused_fin_p[i] = fin[i].p;
        end
    end

    assign w    = stg_q[STAGES-1].pp ^ cy[WIDTH-1:0];
    assign ov   = cy[WIDTH];
    assign sovf = cy[WIDTH] ^ cy[WIDTH-1];

endmodule

// File: tb/tb_ppa_adder_pipe.sv
module tb_ppa_adder_pipe;

    localparam int W = 6;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         c = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, ov, sovf;
    logic [W-1:0] w;

    typedef struct {
        logic [W-1:0] w;
        logic         ov;
        logic         sovf;
        int           t;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic         s;
        logic [W-1:0] ew;
        logic         eov;
        logic         esv;
    } vec_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // results of the most recent tick
    bit           t_fi, t_fo, t_vld, t_rdy, t_have;
    int           t_qsz, t_cyc;
    logic [W-1:0] t_w;
    logic         t_ov, t_sv;
    exp_t         t_e;

    always #5 clk = ~clk;

    ppa_adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
`ifdef PPA_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .w         (w),
        .ov        (ov),
        .sovf      (sovf)
    );

    // Reference: plain integer addition, signed overflow from operand/result signs.
    function automatic exp_t model(input logic [W-1:0] a_, input logic [W-1:0] b_,
                                   input logic c_, input logic s_, input int t_);
        exp_t         e;
        logic [W-1:0] be;
        logic [W:0]   sum;
        be     = s_ ? ~b_ : b_;
        sum    = {1'b0, a_} + {1'b0, be} + {{W{1'b0}}, c_};
        e.w    = sum[W-1:0];
        e.ov   = sum[W];
        e.sovf = (a_[W-1] == be[W-1]) && (sum[W-1] != a_[W-1]);
        e.t    = t_;
        return e;
    endfunction

    // Advance one cycle: sample on the falling edge, update the scoreboard,
    // return just after the next rising edge so inputs can be changed.
    task automatic tick();
        @(negedge clk);
        t_cyc  = cyc;
        t_rdy  = in_ready;
        t_vld  = out_valid;
        t_qsz  = q.size();
        t_fi   = in_valid && in_ready;
        t_fo   = out_valid && out_ready;
        t_w    = w;
        t_ov   = ov;
        t_sv   = sovf;
        t_have = 1'b0;
        if (t_fo && q.size() > 0) begin
            t_e    = q.pop_front();
            t_have = 1'b1;
        end
        if (t_fi) q.push_back(model(a, b, c, sub, cyc));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (w !== '0)           begin bad++; $display("FAIL reset_w: got %h want 0", w); end
        total++; if (ov !== 1'b0)        begin bad++; $display("FAIL reset_ov: got %b want 0", ov); end
        total++; if (sovf !== 1'b0)      begin bad++; $display("FAIL reset_sovf: got %b want 0", sovf); end
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;

        // two beats in flight, then reset: neither may come out
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_async: out_valid=%b want 0", out_valid); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        q.delete();
        out_ready = 1'b1;
        repeat (2 * S + 4) begin
            tick();
            total++; if (t_vld) begin bad++; $display("FAIL reset_flush: out_valid=1 w=%h after reset, want none", t_w); end
        end
    endtask

    task automatic test_corner();
        vec_t v[$];
        bit   got;
        v.push_back('{W'(6'h3F), W'(6'h3F), 1'b1, 1'b0, W'(6'h3F), 1'b1, 1'b0});
        v.push_back('{W'(6'h15), W'(6'h2A), 1'b1, 1'b0, W'(6'h00), 1'b1, 1'b0});
        v.push_back('{W'(6'h1F), W'(6'h01), 1'b0, 1'b0, W'(6'h20), 1'b0, 1'b1});
        v.push_back('{W'(6'h20), W'(6'h3F), 1'b0, 1'b0, W'(6'h1F), 1'b1, 1'b1});
`ifdef PPA_SUB_EN
        v.push_back('{W'(6'h05), W'(6'h03), 1'b1, 1'b1, W'(6'h02), 1'b1, 1'b0});
        v.push_back('{W'(6'h03), W'(6'h05), 1'b1, 1'b1, W'(6'h3E), 1'b0, 1'b0});
`endif
        out_ready = 1'b1;
        foreach (v[n]) begin
            a = v[n].a; b = v[n].b; c = v[n].c; sub = v[n].s; in_valid = 1'b1;
            tick();
            total++; if (!t_fi) begin bad++; $display("FAIL corner_accept[%0d]: accepted=%b want 1", n, t_fi); end
            in_valid = 1'b0; a = W'($urandom); b = W'($urandom); c = 1'($urandom); sub = 1'b0;
            got = 1'b0;
            for (int k = 0; k < S + 4 && !got; k++) begin
                tick();
                if (t_fo) got = 1'b1;
            end
            total++;
            if (!got) begin
                bad++; $display("FAIL corner_timeout[%0d]: no result within %0d cycles", n, S + 4);
            end else begin
                if (t_w !== v[n].ew || t_ov !== v[n].eov || t_sv !== v[n].esv) begin
                    bad++;
                    $display("FAIL corner_value[%0d]: w=%b ov=%b sovf=%b want w=%b ov=%b sovf=%b",
                             n, t_w, t_ov, t_sv, v[n].ew, v[n].eov, v[n].esv);
                end
                total++;
                if (!t_have || (t_cyc - t_e.t) != S) begin
                    bad++; $display("FAIL corner_latency[%0d]: got %0d cycles want %0d", n, t_cyc - t_e.t, S);
                end
            end
        end
    endtask

    task automatic test_ripple();
        int sent = 0;
        int nout = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 10 + S; k++) begin
            if (sent < 10) begin
                in_valid = 1'b1;
                a = W'((1 << (sent % 5 + 1)) - 1);
                b = '1;
                c = (sent >= 5);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            total++; if (t_rdy !== 1'b1) begin bad++; $display("FAIL ripple_in_ready: got %b want 1", t_rdy); end
            if (t_fi) sent++;
            if (t_fo) begin
                nout++;
                total++;
                if (!t_have || t_w !== t_e.w || t_ov !== t_e.ov || t_sv !== t_e.sovf || t_ov !== 1'b1) begin
                    bad++;
                    $display("FAIL ripple_value: w=%b ov=%b sovf=%b want w=%b ov=1 sovf=%b",
                             t_w, t_ov, t_sv, t_e.w, t_e.sovf);
                end
            end
        end
        in_valid = 1'b0;
        total++;
        if (sent != 10 || nout != 10) begin
            bad++; $display("FAIL ripple_count: sent=%0d out=%0d want 10/10 back-to-back", sent, nout);
        end
    endtask

    task automatic test_backpressure();
        int           sent = 0;
        int           k = 0;
        bit           prev_stall = 1'b0;
        bit           exp_rdy;
        logic [W-1:0] pw = '0;
        logic         pov = 1'b0;
        logic         psv = 1'b0;
        while ((sent < 10 || q.size() > 0) && k < 60) begin
            out_ready = !(k >= 4 && k < 8);
            if (sent < 10) begin
                in_valid = 1'b1; a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            exp_rdy = out_ready || (t_qsz < S);
            total++; if (t_rdy !== exp_rdy) begin bad++; $display("FAIL bp_in_ready: got %b want %b held=%0d", t_rdy, exp_rdy, t_qsz); end
            if (prev_stall && t_vld) begin
                total++;
                if (t_w !== pw || t_ov !== pov || t_sv !== psv) begin
                    bad++; $display("FAIL bp_hold: w=%h ov=%b sovf=%b want held w=%h ov=%b sovf=%b", t_w, t_ov, t_sv, pw, pov, psv);
                end
            end
            prev_stall = t_vld && !out_ready;
            pw = t_w; pov = t_ov; psv = t_sv;
            if (t_fi) sent++;
            if (t_fo) begin
                total++;
                if (!t_have || t_w !== t_e.w || t_ov !== t_e.ov || t_sv !== t_e.sovf) begin
                    bad++; $display("FAIL bp_value: w=%h ov=%b sovf=%b want w=%h ov=%b sovf=%b",
                                    t_w, t_ov, t_sv, t_e.w, t_e.ov, t_e.sovf);
                end
            end
            k++;
        end
        in_valid = 1'b0;
        total++;
        if (sent != 10 || q.size() != 0) begin
            bad++; $display("FAIL bp_drain: sent=%0d pending=%0d want 10/0", sent, q.size());
        end
    endtask

    task automatic test_random();
        bit exp_rdy;
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            tick();
            exp_rdy = out_ready || (t_qsz < S);
            total++; if (t_rdy !== exp_rdy) begin bad++; $display("FAIL rand_in_ready: got %b want %b held=%0d", t_rdy, exp_rdy, t_qsz); end
            if (t_fo) begin
                total++;
                if (!t_have || t_w !== t_e.w || t_ov !== t_e.ov || t_sv !== t_e.sovf) begin
                    bad++; $display("FAIL rand_value: w=%h ov=%b sovf=%b want w=%h ov=%b sovf=%b",
                                    t_w, t_ov, t_sv, t_e.w, t_e.ov, t_e.sovf);
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < S + 5 && q.size() > 0; k++) begin
            tick();
            if (t_fo) begin
                total++;
                if (!t_have || t_w !== t_e.w || t_ov !== t_e.ov || t_sv !== t_e.sovf) begin
                    bad++; $display("FAIL rand_drain_value: w=%h ov=%b sovf=%b want w=%h ov=%b sovf=%b",
                                    t_w, t_ov, t_sv, t_e.w, t_e.ov, t_e.sovf);
                end
            end
        end
        total++;
        if (q.size() != 0) begin bad++; $display("FAIL rand_drain: pending=%0d want 0", q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_corner();
        test_ripple();
        test_backpressure();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
